// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter_if
// Brief    : Requester and response bundle for the shared-ALU arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int OP_W    = 4,
   parameter int ID_W    = 3
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*OP_W-1:0]   req_op;
   logic [NUM_REQ*DATA_W-1:0] req_in1;
   logic [NUM_REQ*DATA_W-1:0] req_in2;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [ID_W-1:0]           rsp_id;
   logic [DATA_W-1:0]         rsp_result;
   logic                      rsp_bcond;

   modport master (
      output req_valid, req_op, req_in1, req_in2, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_bcond
   );

   modport slave (
      input  req_valid, req_op, req_in1, req_in2, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_bcond
   );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Shares one combinational ALU among NUM_REQ requesters with a
//            single registered response slot. Round-robin by default;
//            define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int OP_W    = 4,
   parameter int ID_W    = 3
) (
   input  wire logic              clk,
   input  wire logic              reset,
   alu_share_arbiter_if.slave     bus,
   output logic [OP_W-1:0]        alu_op,
   output logic [DATA_W-1:0]      alu_in_1,
   output logic [DATA_W-1:0]      alu_in_2,
   input  wire logic [DATA_W-1:0] alu_result,
   input  wire logic              alu_bcond
);
   localparam logic [ID_W-1:0] c_LAST = ID_W'(NUM_REQ - 1);

   logic                r_rsp_valid;
   logic [ID_W-1:0]     r_rsp_id;
   logic [DATA_W-1:0]   r_rsp_result;
   logic                r_rsp_bcond;

   logic                w_slot_free;
   logic                w_grant;
   logic [ID_W-1:0]     w_winner;
   logic [NUM_REQ-1:0]  w_ready;
   logic [ID_W-1:0]     w_base;
   int                  w_idx;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign w_base = '0;
`else
   logic [ID_W-1:0] r_rr_ptr;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rr_ptr <= '0;
      end else if (w_grant) begin
         r_rr_ptr <= (w_winner == c_LAST) ? '0 : w_winner + 1'b1;
      end
   end

   assign w_base = r_rr_ptr;
`endif

   // Search starts at w_base and wraps; the first valid requester wins.
   always_comb begin
      w_slot_free = !r_rsp_valid || bus.rsp_ready;
      w_grant     = 1'b0;
      w_winner    = '0;
      w_ready     = '0;
      w_idx       = 0;
      alu_op      = '0;
      alu_in_1    = '0;
      alu_in_2    = '0;
      if (reset && w_slot_free) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(w_base) + k;
            if (w_idx >= NUM_REQ) begin
               w_idx = w_idx - NUM_REQ;
            end
            if (!w_grant && bus.req_valid[w_idx]) begin
               w_grant         = 1'b1;
               w_winner        = ID_W'(w_idx);
               w_ready[w_idx]  = 1'b1;
               alu_op          = bus.req_op[w_idx*OP_W +: OP_W];
               alu_in_1        = bus.req_in1[w_idx*DATA_W +: DATA_W];
               alu_in_2        = bus.req_in2[w_idx*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Drain and refill on the same edge keeps one op per cycle under rsp_ready.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= '0;
         r_rsp_result <= '0;
         r_rsp_bcond  <= 1'b0;
      end else if (w_grant) begin
         r_rsp_valid  <= 1'b1;
         r_rsp_id     <= w_winner;
         r_rsp_result <= alu_result;
         r_rsp_bcond  <= alu_bcond;
      end else if (r_rsp_valid && bus.rsp_ready) begin
         r_rsp_valid  <= 1'b0;
      end
   end

   assign bus.req_ready  = w_ready;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_id     = r_rsp_id;
   assign bus.rsp_result = r_rsp_result;
   assign bus.rsp_bcond  = r_rsp_bcond;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Randomized scoreboard bench for alu_share_arbiter (NUM_REQ=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
   localparam int N  = 2;
   localparam int DW = 32;
   localparam int OW = 4;
   localparam int IW = 3;

   localparam logic [OW-1:0] c_ADD = 4'd0, c_SUB = 4'd1, c_AND = 4'd2,
                             c_OR  = 4'd3, c_XOR = 4'd4, c_SLT = 4'd5,
                             c_BEQ = 4'd8, c_BNE = 4'd9, c_BLT = 4'd10,
                             c_BGE = 4'd11;

   typedef struct packed {
      logic [DW-1:0] res;
      logic          bc;
   } alu_out_t;

   typedef struct {
      int            id;
      logic [DW-1:0] res;
      logic          bc;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   alu_share_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .ID_W(IW)) bus ();

   logic [OW-1:0] alu_op;
   logic [DW-1:0] alu_in_1, alu_in_2, alu_result;
   logic          alu_bcond;

   alu_share_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .ID_W(IW)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.slave),
      .alu_op     (alu_op),
      .alu_in_1   (alu_in_1),
      .alu_in_2   (alu_in_2),
      .alu_result (alu_result),
      .alu_bcond  (alu_bcond)
   );

   function automatic alu_out_t alu_ref(logic [OW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
      alu_out_t o;
      o = '0;
      case (op)
         c_ADD: o.res = a + b;
         c_SUB: o.res = a - b;
         c_AND: o.res = a & b;
         c_OR:  o.res = a | b;
         c_XOR: o.res = a ^ b;
         c_SLT: o.res = {31'd0, $signed(a) < $signed(b)};
         c_BEQ: o.bc  = (a == b);
         c_BNE: o.bc  = (a != b);
         c_BLT: o.bc  = ($signed(a) < $signed(b));
         c_BGE: o.bc  = ($signed(a) >= $signed(b));
         default: o = '0;
      endcase
      return o;
   endfunction

   // Stand-in for the shared ALU instance.
   always_comb begin
      {alu_result, alu_bcond} = alu_ref(alu_op, alu_in_1, alu_in_2);
   end

   // Requester state, packed onto the bus.
   logic          v  [N];
   logic [OW-1:0] op [N];
   logic [DW-1:0] a  [N];
   logic [DW-1:0] b  [N];
   logic          rsp_rdy;

   always_comb begin
      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_in1   = '0;
      bus.req_in2   = '0;
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]          = v[i];
         bus.req_op[i*OW +: OW]    = op[i];
         bus.req_in1[i*DW +: DW]   = a[i];
         bus.req_in2[i*DW +: DW]   = b[i];
      end
      bus.rsp_ready = rsp_rdy;
   end

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t q [$];
   int   ptr  = 0;
   bit   slot = 1'b0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arbitration: scan requesters in order starting at ptr.
   task automatic tick();
      int           w;
      logic [N-1:0] er;
      alu_out_t     r;
      exp_t         e;
      #1;
      w  = -1;
      er = '0;
      if (reset && (!slot || rsp_rdy)) begin
         for (int k = 0; k < N; k++) begin
            if (w < 0 && v[(ptr + k) % N]) w = (ptr + k) % N;
         end
      end
      if (w >= 0) er[w] = 1'b1;
      check("req_ready", 64'(bus.req_ready), 64'(er));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(slot));
      if (w >= 0) begin
         r    = alu_ref(op[w], a[w], b[w]);
         e.id = w;
         e.res = r.res;
         e.bc = r.bc;
         q.push_back(e);
`ifndef ALU_ARB_FIXED_PRIO_EN
         ptr = (w + 1) % N;
`endif
         slot = 1'b1;
      end else if (slot && rsp_rdy) begin
         slot = 1'b0;
      end
      if (!reset) begin
         slot = 1'b0;
         ptr  = 0;
         q.delete();
      end
      @(negedge clk);
      if (w >= 0) v[w] = 1'b0;
   endtask

   // Monitor: a response leaves the slot on the edge where valid && ready.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (reset && bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0) begin
               check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
            end else begin
               e = q.pop_front();
               check("rsp_id",     64'(bus.rsp_id),     64'(e.id));
               check("rsp_result", 64'(bus.rsp_result), 64'(e.res));
               check("rsp_bcond",  64'(bus.rsp_bcond),  64'(e.bc));
            end
         end
      end
   end

   task automatic set_req(int i, logic [OW-1:0] o, logic [DW-1:0] x, logic [DW-1:0] y);
      v[i]  = 1'b1;
      op[i] = o;
      a[i]  = x;
      b[i]  = y;
   endtask

   logic [OW-1:0] ops_tab [10];

   initial begin
      ops_tab = '{c_ADD, c_SUB, c_AND, c_OR, c_XOR, c_SLT, c_BEQ, c_BNE, c_BLT, c_BGE};
      for (int i = 0; i < N; i++) begin
         v[i] = 1'b0; op[i] = '0; a[i] = '0; b[i] = '0;
      end
      rsp_rdy = 1'b1;
      @(negedge clk);

      // Reset held with both requesting: no grants, empty slot.
      set_req(0, c_ADD, 32'd1, 32'd2);
      set_req(1, c_SUB, 32'd9, 32'd4);
      tick();
      tick();
      reset = 1'b1;
      tick();
      tick();

      // Single ADD on requester 0.
      set_req(0, c_ADD, 32'd5, 32'd7);
      tick();
      check("add_id", 64'(bus.rsp_id), 64'd0);
      check("add_result", 64'(bus.rsp_result), 64'd12);

      // Branch compares on requester 1.
      set_req(1, c_BEQ, 32'h1234, 32'h1234);
      tick();
      check("beq_id", 64'(bus.rsp_id), 64'd1);
      check("beq_bcond", 64'(bus.rsp_bcond), 64'd1);
      check("beq_result", 64'(bus.rsp_result), 64'd0);
      set_req(1, c_BNE, 32'h1234, 32'h1234);
      tick();
      check("bne_bcond", 64'(bus.rsp_bcond), 64'd0);

      // Backpressure: held response, no grants for 3 cycles.
      set_req(0, c_XOR, 32'hF0F0, 32'h0FF0);
      set_req(1, c_OR,  32'h0001, 32'h0100);
      rsp_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_id", 64'(bus.rsp_id), 64'd1);
         check("stall_bcond", 64'(bus.rsp_bcond), 64'd0);
      end
      rsp_rdy = 1'b1;
      tick();
      tick();
      tick();

      // Randomized traffic with backpressure and occasional resets.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!v[i] && $urandom_range(0, 2) != 0) begin
               logic [DW-1:0] x;
               x = $urandom;
               set_req(i, ops_tab[$urandom_range(0, 9)], x,
                       ($urandom_range(0, 3) == 0) ? x : DW'($urandom));
            end
         end
         rsp_rdy = ($urandom_range(0, 3) != 0);
         reset   = ($urandom_range(0, 60) != 0);
         tick();
      end
      reset = 1'b1;

      // Mid-operation reset: pending response dropped, pointer back to 0.
      v[1] = 1'b0;
      rsp_rdy = 1'b1;
      tick();
      set_req(0, c_ADD, 32'd3, 32'd4);
      tick();
      set_req(0, c_SUB, 32'd10, 32'd3);
      set_req(1, c_AND, 32'hFF, 32'h0F);
      rsp_rdy = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      rsp_rdy = 1'b1;
      tick();
      check("post_reset_id", 64'(bus.rsp_id), 64'd0);
      check("post_reset_result", 64'(bus.rsp_result), 64'd7);

      // Both continuously valid for several grants.
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!v[i]) set_req(i, c_ADD, DW'(c), DW'(i));
         end
         tick();
      end

      // Drain.
      for (int i = 0; i < N; i++) v[i] = 1'b0;
      rsp_rdy = 1'b1;
      tick();
      tick();
      tick();
      check("queue_empty", 64'(q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Arbitrates one shared combinational ALU (the ALU / ALUControlUnit pair) between NUM_REQ requesters, e.g. EX stage, branch-resolve unit and a multi-cycle helper.
- Each requester presents op plus two operands with a valid/ready handshake.
- The arbiter grants one requester per cycle, drives the ALU inputs, and registers the result into a single response slot tagged with the winner's id.
- Sits between the requesters and the ALU instance in the core top level.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 32, operand/result width.
- OP_W, 4, alu_op width.
- ID_W, 3, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-low; sampled on clk rising edge.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_op  in  NUM_REQ*OP_W  flattened ops; requester i at [i*OP_W +: OP_W].
- req_in1  in  NUM_REQ*DATA_W  flattened operand 1.
- req_in2  in  NUM_REQ*DATA_W  flattened operand 2.
- alu_op  out  OP_W  to ALU.
- alu_in_1  out  DATA_W  to ALU.
- alu_in_2  out  DATA_W  to ALU.
- alu_result  in  DATA_W  from ALU.
- alu_bcond  in  1  from ALU.
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  ID_W  index of requester that produced the response.
- rsp_result  out  DATA_W  registered alu_result.
- rsp_bcond  out  1  registered alu_bcond; meaningful only for branch ops.

Behaviour:
- Reset (reset==0 at edge):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_bcond=0.
  - Round-robin pointer rr_ptr=0.
- While reset is low, req_ready is forced to 0 combinationally.
- Slot free condition: slot_free = !rsp_valid || rsp_ready.
- Grant (combinational, same cycle):
  - If slot_free and any req_valid, winner = first i with req_valid[i], searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[winner]=1; all other req_ready bits are 0.
  - If the slot is not free, req_ready=0 for all requesters (stall).
- Handshake: a request transfers when req_valid[i] && req_ready[i].
  - Requester must hold op and operands stable while valid and not ready.
  - The arbiter never drops a valid request.
- ALU drive:
  - alu_op/alu_in_1/alu_in_2 = winner's fields when a grant occurs.
  - Otherwise all zero, to avoid toggling.
- Edge with grant:
  - rsp_result<=alu_result, rsp_bcond<=alu_bcond, rsp_id<=winner, rsp_valid<=1.
  - rr_ptr<=(winner+1) mod NUM_REQ.
- Edge without grant:
  - If rsp_valid && rsp_ready then rsp_valid<=0.
  - Data fields hold their values.
  - rr_ptr holds.
- Latency: request accepted in cycle T -> response visible (rsp_valid=1) in T+1.
- Throughput: 1 op/cycle when rsp_ready is held high, because drain and refill happen on the same edge.
- Stall: rsp_valid=1 && rsp_ready=0 -> no grants; the response is held stable until accepted.
- Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once per NUM_REQ grants.
- Single requester: granted every cycle regardless of rr_ptr.
- Reset mid-operation:
  - A pending response is discarded (rsp_valid=0 next cycle).
  - No grant occurs in the reset cycle.
  - Requesters re-present after reset deasserts.
- Width rule: DATA_W and OP_W are passed straight through with no extension.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is removed and stays constant 0; a higher index may starve.
- Undefined (default): round-robin as specified above.
- Handshake, latency and stall rules are identical in both builds.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req_valid=2'b11 -> req_ready=0, rsp_valid=0 throughout; first grant after release goes to requester 0.
- Single op: req0 valid with ADD op, in1=5, in2=7, rsp_ready=1 -> req_ready[0]=1 in T; in T+1 rsp_valid=1, rsp_id=0, rsp_result=12.
- Round-robin: both requesters valid for 6 cycles, rsp_ready=1 -> grant sequence 0,1,0,1,0,1, one response per cycle.
- Backpressure: response pending with rsp_ready=0 for 3 cycles -> req_ready=0, rsp_* stable; on rsp_ready=1 the next grant issues in the same cycle and the new response appears the following cycle.
- Branch op: req1 BEQ op, in1=in2=0x1234 -> rsp_id=1, rsp_bcond=1, rsp_result=0. Then BNE op with the same operands -> rsp_bcond=0.
- Mid-operation reset: reset=0 while rsp_valid=1 -> rsp_valid=0 next edge; rr_ptr=0, so requester 0 wins first after release. With ALU_ARB_FIXED_PRIO_EN defined, both valid for 4 cycles -> all 4 grants go to requester 0.
